// File: rtl/seq_det_arbiter.sv
// Shared "101" Mealy detector serving NCH serial streams. A round-robin arbiter
// picks one stream per cycle, and each stream keeps its own saved detector context.
module seq_det_arbiter #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CW    = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req_valid,
  input  logic [NCH-1:0]   req_bit,
  output logic [NCH-1:0]   req_ready,
  input  logic             clr_valid,
  input  logic [CW-1:0]    clr_ch,
  output logic             match_valid,
  output logic [CW-1:0]    match_ch,
  input  logic [CW-1:0]    cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } state_t;

  state_t           r_ctx [NCH];
  logic [CNT_W-1:0] r_cnt [NCH];
  logic [CW-1:0]    r_last_grant;
  logic             r_match_valid;
  logic [CW-1:0]    r_match_ch;

  logic [NCH-1:0]   w_clr_mask;
  logic [NCH-1:0]   w_cand;
  logic [NCH-1:0]   w_gnt;
  logic [CW-1:0]    w_idx;
  logic [CW-1:0]    w_gnt_idx;
  logic             w_xfer;
  state_t           w_cur;
  state_t           w_nxt;
  logic             w_bit;
  logic             w_hit;

  // A channel being cleared is withheld from arbitration so its bit stays pending.
  always_comb begin
    w_clr_mask = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (clr_valid && (clr_ch == CW'(i))) w_clr_mask[i] = 1'b1;
    end
    w_cand = req_valid & ~w_clr_mask;
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_idx     = '0;
    w_xfer    = 1'b0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      w_idx = CW'((32'(r_last_grant) + k) % NCH);
      if (!w_xfer && w_cand[w_idx]) begin
        w_xfer        = 1'b1;
        w_gnt[w_idx]  = 1'b1;
        w_gnt_idx     = w_idx;
      end
    end
    if (rst) begin
      w_gnt  = '0;
      w_xfer = 1'b0;
    end
  end

  assign req_ready = w_gnt;

  // Next-state and match decode for the granted channel's restored context.
  always_comb begin
    w_cur = r_ctx[w_gnt_idx];
    w_bit = req_bit[w_gnt_idx];
    w_nxt = S0;
    w_hit = 1'b0;
    case (w_cur)
      S0:      w_nxt = w_bit ? S1 : S0;
      S1:      w_nxt = w_bit ? S1 : S2;
      S2: begin
        w_nxt = w_bit ? S1 : S0;
        w_hit = w_bit;
      end
      default: w_nxt = S0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_ctx[i] <= S0;
        r_cnt[i] <= '0;
      end
      r_last_grant  <= CW'(NCH - 1);
      r_match_valid <= 1'b0;
      r_match_ch    <= '0;
    end else begin
      r_match_valid <= w_xfer && w_hit;
      if (w_xfer) begin
        r_last_grant <= w_gnt_idx;
        if (w_hit) r_match_ch <= w_gnt_idx;
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        if (w_clr_mask[i]) begin
          r_ctx[i] <= S0;
          r_cnt[i] <= '0;
        end else if (w_gnt[i]) begin
          r_ctx[i] <= w_nxt;
          if (w_hit && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Counter read mux; an out-of-range select reads zero.
  always_comb begin
    cnt_out = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cnt_sel == CW'(i)) cnt_out = r_cnt[i];
    end
  end

  assign match_valid = r_match_valid;
  assign match_ch    = r_match_ch;

endmodule

// File: doc/seq_det_arbiter.md
Name: seq_det_arbiter

Overview:
- Shares a single "101" Mealy detection engine among NCH independent serial bit streams.
- Each requester offers one bit per transfer using a valid/ready handshake. A round-robin arbiter grants at most one channel per cycle.
- Per-channel detector context is saved and restored, so every stream is detected as if it had its own detector.
- A registered match pulse is tagged with the channel id. Per-channel saturating match counters are readable by software/test logic.

Parameters:
- NCH, 4, number of requesting channels (2..16)
- CW, 2, channel id width, clog2(NCH)
- CNT_W, 8, per-channel match counter width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NCH  channel i presents a bit
- req_bit  input  NCH  serial bit of channel i
- req_ready  output  NCH  channel i bit accepted this cycle (combinational)
- clr_valid  input  1  clear request for one channel
- clr_ch  input  CW  channel to clear
- match_valid  output  1  one-cycle pulse: accepted bit completed "101"
- match_ch  output  CW  channel of current match
- cnt_sel  input  CW  counter read select
- cnt_out  output  CNT_W  match count of channel cnt_sel (combinational)

Behaviour:
- Reset (async, rst=1):
  - all contexts = S0, all counters = 0
  - match_valid=0, match_ch=0
  - RR pointer last_grant=NCH-1, so channel 0 has first priority
  - req_ready=0 while rst is high
- Arbitration:
  - Candidates are channels with req_valid=1, excluding clr_ch when clr_valid=1.
  - Search starts at last_grant+1, wraps modulo NCH, and picks the first candidate.
  - req_ready is one-hot or zero; at most one transfer per cycle.
  - A transfer occurs when req_valid[i] & req_ready[i] are both high.
  - last_grant updates only on a transfer.
  - req_ready must not depend on req_bit.
- Context FSM, per channel, 2 bits, updated only for the transferring channel:
  - S0 (nothing): bit 1 -> S1, bit 0 -> S0
  - S1 (seen "1"): bit 1 -> S1, bit 0 -> S2
  - S2 (seen "10"): bit 1 -> S1 with match, bit 0 -> S0
  - Overlap is allowed: "10101" yields two matches.
  - Unencoded state value 11 -> S0.
  - Non-transferring channels hold their context.
- Match output, latency 1:
  - Edge after a match transfer: match_valid=1, match_ch=channel.
  - Otherwise match_valid=0; match_ch holds its last value.
  - Back-to-back matches on different channels give consecutive pulses.
- Counters:
  - Increment on the same edge that match_valid rises.
  - Saturate at 2^CNT_W-1; no wrap.
  - cnt_out reflects the registered value.
- Clear:
  - clr_valid=1 at an edge sets context[clr_ch]=S0 and counter[clr_ch]=0.
  - That channel is not granted that cycle; its offered bit is not consumed and stays pending.
  - Other channels may transfer in the same cycle.
  - clr_ch >= NCH: ignored.
- Reset mid-operation:
  - Immediate return to reset values; pending bits are lost.
  - The first post-reset grant goes to the lowest valid channel.

Test Plan:
- Ch0 only, bits 1,0,1,1,0,1 -> match_valid pulses after 3rd and 6th transfers, match_ch=0, cnt(0)=2.
- Ch2 only, overlap 1,0,1,0,1 -> two pulses (after 3rd and 5th bits), cnt(2)=2; then 0,0,1 -> no pulse.
- All four valid continuously -> grant order 0,1,2,3,0,1,...; each channel gets 1 of 4 cycles.
  - Drop ch1 valid -> order 0,2,3,0.
- Context isolation: ch0 sends 1,0; ch1 sends 1,0,0; ch0 sends 1 -> exactly one match, match_ch=0; cnt(1)=0.
- Saturation with CNT_W=2: ch3 sends "101" x5 (overlapped 1,0,1,0,1,...) -> cnt(3) stops at 3; pulses still occur.
- Clear and reset:
  - ch1 at S2 plus clr_valid=1, clr_ch=1 with req_valid[1]=1 -> no ready for ch1 that cycle, cnt(1)=0. Next bit 1 (accepted) -> no match, context S1.
  - rst asserted mid-stream -> all outputs and counters 0 immediately.
